// File: rtl/multi_freq_serial_out.sv
// Byte-command driven multi-channel serial pattern generator.
// Each pattern bit is held for one of several programmable periods.
`timescale 1ns/1ps
module multi_freq_serial_out #(
  parameter int unsigned DATA_BIT   = 32,
  parameter int unsigned OUTPUT_NUM = 16,
  parameter int unsigned PERIOD_NUM = 4,
  parameter int unsigned PERIOD_W   = 8,
  parameter logic [PERIOD_NUM*PERIOD_W-1:0] DEFAULT_PERIODS = {8'd40, 8'd10, 8'd5, 8'd20},
  parameter logic [7:0] CMD_DATA   = 8'h01,
  parameter logic [7:0] CMD_CTRL   = 8'h02,
  parameter logic [7:0] CMD_FREQ   = 8'h03,
  parameter logic [7:0] CMD_PERIOD = 8'h04,
  parameter logic [7:0] CMD_STOP   = 8'h05
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [7:0]            data_i,
  input  logic                  rx_done_tick_i,
  output logic [OUTPUT_NUM-1:0] serial_out_o,
  output logic [OUTPUT_NUM-1:0] busy_o,
  output logic [OUTPUT_NUM-1:0] done_tick_o,
  output logic                  cmd_err_o
);

  localparam int unsigned SEL_W      = $clog2(PERIOD_NUM);
  localparam int unsigned IDX_W      = $clog2(DATA_BIT);
  localparam int unsigned FREQ_W     = DATA_BIT * SEL_W;
  localparam int unsigned DATA_BYTES = DATA_BIT / 8;
  localparam int unsigned FREQ_BYTES = FREQ_W / 8;
  localparam int unsigned PER_BITS   = PERIOD_NUM * 8;
  localparam int unsigned BUF_A      = (DATA_BIT > FREQ_W) ? DATA_BIT : FREQ_W;
  localparam int unsigned BUF_W      = (BUF_A > PER_BITS) ? BUF_A : PER_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_CTRL, S_FREQ, S_PERIOD, S_STOP
  } state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]                         r_cnt;
  logic [7:0]                         r_ch;
  logic [2:0]                         r_ctrl;
  logic [BUF_W-9:0]                   r_buf;
  logic [FREQ_W-1:0]                  r_freq;
  logic [PERIOD_NUM-1:0][PERIOD_W-1:0] r_period;
  logic                               r_cmd_err;
  logic [OUTPUT_NUM-1:0]              r_go;
  logic [OUTPUT_NUM-1:0]              r_stop;
  logic [1:0]                         r_go_mode;
  logic [7:0]                         r_go_rep;

  logic [BUF_W-1:0]      w_buf_nxt;
  logic [DATA_BIT-1:0]   w_data_val;
  logic [7:0]            w_ch;
  logic                  w_ch_ok;
  logic [OUTPUT_NUM-1:0] w_ch_mask;
  logic                  w_last;
  logic                  w_err;
  logic [OUTPUT_NUM-1:0] w_go;
  logic [OUTPUT_NUM-1:0] w_stop;
  logic [OUTPUT_NUM-1:0] w_data_we;
  logic                  w_freq_we;
  logic                  w_period_we;

  // Multi-byte payloads are assembled LSB-first; the newest byte lands on top.
  assign w_buf_nxt  = {data_i, r_buf};
  assign w_data_val = w_buf_nxt[BUF_W-1 -: DATA_BIT];
  assign w_ch       = (r_state == S_STOP) ? data_i : r_ch;
  assign w_ch_ok    = 32'(w_ch) < OUTPUT_NUM;
  assign w_ch_mask  = OUTPUT_NUM'(1) << w_ch;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Parser next state and per-command decode on the final byte.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    w_err       = 1'b0;
    w_go        = '0;
    w_stop      = '0;
    w_data_we   = '0;
    w_freq_we   = 1'b0;
    w_period_we = 1'b0;
    if (rx_done_tick_i) begin
      case (r_state)
        S_IDLE: begin
          case (data_i)
            CMD_DATA:   w_state_nxt = S_DATA;
            CMD_CTRL:   w_state_nxt = S_CTRL;
            CMD_FREQ:   w_state_nxt = S_FREQ;
            CMD_PERIOD: w_state_nxt = S_PERIOD;
            CMD_STOP:   w_state_nxt = S_STOP;
            default:    w_err       = 1'b1;
          endcase
        end
        S_DATA: begin
          if (r_cnt == 8'(DATA_BYTES)) begin
            w_last = 1'b1;
            if (w_ch_ok) w_data_we = w_ch_mask;
            else         w_err     = 1'b1;
          end
        end
        S_CTRL: begin
          if (r_cnt == 8'd2) begin
            w_last = 1'b1;
            if (!w_ch_ok) begin
              w_err = 1'b1;
            end else if (r_ctrl[2:1] == 2'b11) begin
              w_err  = 1'b1;
              w_stop = w_ch_mask;
            end else if (r_ctrl[0]) begin
              w_go = w_ch_mask;
            end else begin
              w_stop = w_ch_mask;
            end
          end
        end
        S_FREQ: begin
          if (r_cnt == 8'(FREQ_BYTES - 1)) begin
            w_last    = 1'b1;
            w_freq_we = 1'b1;
          end
        end
        S_PERIOD: begin
          if (r_cnt == 8'(PERIOD_NUM - 1)) begin
            w_last      = 1'b1;
            w_period_we = 1'b1;
          end
        end
        S_STOP: begin
          w_last = 1'b1;
          if (data_i == 8'hFF) w_stop = '1;
          else if (w_ch_ok)    w_stop = w_ch_mask;
          else                 w_err  = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_last) w_state_nxt = S_IDLE;
    end
  end

  // Parser datapath and global timing configuration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_ch      <= '0;
      r_ctrl    <= '0;
      r_buf     <= '0;
      r_freq    <= '0;
      r_period  <= DEFAULT_PERIODS;
      r_cmd_err <= 1'b0;
      r_go      <= '0;
      r_stop    <= '0;
      r_go_mode <= '0;
      r_go_rep  <= '0;
    end else begin
      r_cmd_err <= w_err;
      r_go      <= w_go;
      r_stop    <= w_stop;
      if (rx_done_tick_i) begin
        r_buf <= w_buf_nxt[BUF_W-1:8];
        r_cnt <= (r_state == S_IDLE || w_last) ? 8'd0 : r_cnt + 8'd1;
        if (r_state != S_IDLE && r_cnt == 8'd0) r_ch <= data_i;
        if (r_state == S_CTRL && r_cnt == 8'd1) r_ctrl <= data_i[2:0];
      end
      if (w_go != '0) begin
        r_go_mode <= r_ctrl[2:1];
        r_go_rep  <= data_i;
      end
      if (w_freq_we) r_freq <= w_buf_nxt[BUF_W-1 -: FREQ_W];
      if (w_period_we) begin
        for (int i = 0; i < PERIOD_NUM; i++) begin
          r_period[i] <= PERIOD_W'(w_buf_nxt[BUF_W - PER_BITS + i*8 +: 8]);
        end
      end
    end
  end

  logic [DATA_BIT-1:0] r_shadow     [OUTPUT_NUM];
  logic [DATA_BIT-1:0] r_active     [OUTPUT_NUM];
  logic [DATA_BIT-1:0] w_shadow_nxt [OUTPUT_NUM];
  logic [IDX_W-1:0]    r_idx        [OUTPUT_NUM];
  logic [PERIOD_W-1:0] r_tmr        [OUTPUT_NUM];
  logic [7:0]          r_runs       [OUTPUT_NUM];
  logic [1:0]          r_mode       [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0] r_ser, r_busy, r_done;

  always_comb begin
    for (int c = 0; c < OUTPUT_NUM; c++) begin
      w_shadow_nxt[c] = w_data_we[c] ? w_data_val : r_shadow[c];
    end
  end

  // Hold-count reload for bit b: period selected by the freq pattern, 0 acts as 1.
  function automatic logic [PERIOD_W-1:0] f_tmr_init(input logic [IDX_W-1:0] b);
    logic [SEL_W-1:0]    sel;
    logic [PERIOD_W-1:0] per;
    sel = r_freq[32'(b) * SEL_W +: SEL_W];
    per = r_period[sel];
    return (per == '0) ? '0 : per - PERIOD_W'(1);
  endfunction

  // Per-channel run engine; a new CTRL takes priority over completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < OUTPUT_NUM; c++) begin
        r_shadow[c] <= '0;
        r_active[c] <= '0;
        r_idx[c]    <= '0;
        r_tmr[c]    <= '0;
        r_runs[c]   <= '0;
        r_mode[c]   <= '0;
      end
      r_ser  <= '0;
      r_busy <= '0;
      r_done <= '0;
    end else begin
      for (int c = 0; c < OUTPUT_NUM; c++) begin
        r_done[c]   <= 1'b0;
        r_shadow[c] <= w_shadow_nxt[c];
        if (w_data_we[c] && !r_busy[c]) r_active[c] <= w_data_val;
        if (r_go[c]) begin
          r_active[c] <= w_shadow_nxt[c];
          r_idx[c]    <= '0;
          r_tmr[c]    <= f_tmr_init('0);
          r_ser[c]    <= w_shadow_nxt[c][0];
          r_busy[c]   <= 1'b1;
          r_mode[c]   <= r_go_mode;
          r_runs[c]   <= (r_go_rep == 8'd0) ? 8'd1 : r_go_rep;
        end else if (r_stop[c]) begin
          r_busy[c] <= 1'b0;
          r_ser[c]  <= 1'b0;
        end else if (r_busy[c]) begin
          if (r_tmr[c] != '0) begin
            r_tmr[c] <= r_tmr[c] - PERIOD_W'(1);
          end else if (r_idx[c] != IDX_W'(DATA_BIT - 1)) begin
            r_idx[c] <= r_idx[c] + IDX_W'(1);
            r_tmr[c] <= f_tmr_init(r_idx[c] + IDX_W'(1));
            r_ser[c] <= r_active[c][r_idx[c] + IDX_W'(1)];
          end else if (r_mode[c] == 2'b01 || (r_mode[c] == 2'b10 && r_runs[c] > 8'd1)) begin
            if (r_mode[c] == 2'b10) r_runs[c] <= r_runs[c] - 8'd1;
            r_active[c] <= w_shadow_nxt[c];
            r_idx[c]    <= '0;
            r_tmr[c]    <= f_tmr_init('0);
            r_ser[c]    <= w_shadow_nxt[c][0];
          end else begin
            r_busy[c] <= 1'b0;
            r_ser[c]  <= 1'b0;
            r_done[c] <= 1'b1;
          end
        end
      end
    end
  end

  assign serial_out_o = r_ser;
  assign busy_o       = r_busy;
  assign done_tick_o  = r_done;
  assign cmd_err_o    = r_cmd_err;

endmodule

// File: tb/tb_multi_freq_serial_out.sv
// Directed bench for multi_freq_serial_out: command parsing, bit timing, run modes, reset.
`timescale 1ns/1ps
module tb_multi_freq_serial_out;

  localparam int unsigned NCH = 16;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [7:0]     data_i;
  logic           rx_done_tick_i;
  logic [NCH-1:0] serial_out_o;
  logic [NCH-1:0] busy_o;
  logic [NCH-1:0] done_tick_o;
  logic           cmd_err_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  multi_freq_serial_out dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .data_i         (data_i),
    .rx_done_tick_i (rx_done_tick_i),
    .serial_out_o   (serial_out_o),
    .busy_o         (busy_o),
    .done_tick_o    (done_tick_o),
    .cmd_err_o      (cmd_err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    data_i         = b;
    rx_done_tick_i = 1'b1;
    @(negedge clk_i);
    rx_done_tick_i = 1'b0;
  endtask

  task automatic send_ctrl(input logic [7:0] ch, input logic [7:0] ctrl, input logic [7:0] rep);
    send_byte(8'h02); send_byte(ch); send_byte(ctrl); send_byte(rep);
  endtask

  task automatic send_data(input logic [7:0] ch, input logic [31:0] d);
    send_byte(8'h01); send_byte(ch);
    for (int i = 0; i < 4; i++) send_byte(d[i*8 +: 8]);
  endtask

  task automatic send_period(input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3);
    send_byte(8'h04); send_byte(p0); send_byte(p1); send_byte(p2); send_byte(p3);
  endtask

  // Samples one channel for n cycles starting at the edge after the current one.
  task automatic measure(input int ch, input int n, output int busy_n, output int last_busy,
                         output int hi_n, output int first_hi, output int last_hi,
                         output int done_n, output int done_at);
    busy_n = 0; last_busy = 0; hi_n = 0; first_hi = 0; last_hi = 0; done_n = 0; done_at = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_i);
      if (busy_o[ch])      begin busy_n++; last_busy = i; end
      if (serial_out_o[ch]) begin hi_n++; if (first_hi == 0) first_hi = i; last_hi = i; end
      if (done_tick_o[ch]) begin done_n++; done_at = i; end
    end
  endtask

  int bn, lb, hn, fh, lh, dn, da, t0, hi, dcnt;

  initial begin
    rst_ni         = 1'b0;
    data_i         = 8'h00;
    rx_done_tick_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_serial", 64'(serial_out_o), 64'h0);
    chk("rst_busy",   64'(busy_o),       64'h0);
    chk("rst_done",   64'(done_tick_o),  64'h0);
    chk("rst_err",    64'(cmd_err_o),    64'h0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // 1: zero pattern on ch0, default sel 0 -> period 20
    send_ctrl(8'd0, 8'h01, 8'd0);
    chk("t1_busy_before_edge1", 64'(busy_o[0]), 64'h0);
    measure(0, 700, bn, lb, hn, fh, lh, dn, da);
    chk("t1_busy_cycles", 64'(bn), 64'd640);
    chk("t1_busy_last",   64'(lb), 64'd640);
    chk("t1_high_cycles", 64'(hn), 64'd0);
    chk("t1_done_count",  64'(dn), 64'd1);
    chk("t1_done_at",     64'(da), 64'd641);

    // 2: sels 0,1,2,3 repeating with periods 20,5,10,40
    send_byte(8'h03);
    for (int i = 0; i < 8; i++) send_byte(8'hE4);
    send_period(8'd20, 8'd5, 8'd10, 8'd40);
    send_data(8'd3, 32'h0000_000F);
    send_ctrl(8'd3, 8'h01, 8'd0);
    measure(3, 650, bn, lb, hn, fh, lh, dn, da);
    chk("t2_busy_cycles", 64'(bn), 64'd600);
    chk("t2_high_cycles", 64'(hn), 64'd75);
    chk("t2_first_high",  64'(fh), 64'd1);
    chk("t2_last_high",   64'(lh), 64'd75);
    chk("t2_done_at",     64'(da), 64'd601);

    // 3: repeat-N with 3 runs, then repcnt 0
    send_data(8'd5, 32'h5555_5555);
    send_ctrl(8'd5, 8'h05, 8'd3);
    measure(5, 1850, bn, lb, hn, fh, lh, dn, da);
    chk("t3_busy_cycles", 64'(bn), 64'd1800);
    chk("t3_busy_last",   64'(lb), 64'd1800);
    chk("t3_high_cycles", 64'(hn), 64'd720);
    chk("t3_done_count",  64'(dn), 64'd1);
    chk("t3_done_at",     64'(da), 64'd1801);
    send_ctrl(8'd5, 8'h05, 8'd0);
    measure(5, 650, bn, lb, hn, fh, lh, dn, da);
    chk("t3_rep0_busy",   64'(bn), 64'd600);
    chk("t3_rep0_done",   64'(dn), 64'd1);

    // 4: repeat mode with mid-run data update, then global stop
    send_ctrl(8'd7, 8'h03, 8'd0);
    t0 = cyc;
    repeat (100) @(negedge clk_i);
    send_data(8'd7, 32'hFFFF_FFFF);
    hi = 0; dcnt = 0;
    while (cyc < t0 + 600) begin
      @(negedge clk_i);
      if (serial_out_o[7]) hi++;
      if (done_tick_o[7]) dcnt++;
    end
    chk("t4_old_run_low",  64'(hi), 64'd0);
    @(negedge clk_i);
    chk("t4_new_run_high", 64'(serial_out_o[7]), 64'h1);
    repeat (100) @(negedge clk_i);
    chk("t4_still_high",   64'(serial_out_o[7]), 64'h1);
    chk("t4_still_busy",   64'(busy_o[7]),       64'h1);
    chk("t4_no_done",      64'(dcnt),            64'd0);
    send_ctrl(8'd5, 8'h03, 8'd0);
    send_byte(8'h05); send_byte(8'hFF);
    chk("t4_busy_pre_stop",  64'(busy_o), 64'h00A0);
    @(negedge clk_i);
    chk("t4_stop_busy",      64'(busy_o),       64'h0);
    chk("t4_stop_serial",    64'(serial_out_o), 64'h0);
    dcnt = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (done_tick_o != '0) dcnt++;
    end
    chk("t4_stop_no_done",   64'(dcnt), 64'd0);

    // 5: malformed commands
    send_byte(8'h7E);
    chk("t5_unknown_err",    64'(cmd_err_o), 64'h1);
    @(negedge clk_i);
    chk("t5_err_one_cycle",  64'(cmd_err_o), 64'h0);
    chk("t5_unknown_busy",   64'(busy_o),    64'h0);
    send_byte(8'h02); send_byte(8'd16); send_byte(8'h01);
    chk("t5_badch_no_early", 64'(cmd_err_o), 64'h0);
    send_byte(8'h00);
    chk("t5_badch_err",      64'(cmd_err_o), 64'h1);
    @(negedge clk_i);
    chk("t5_badch_no_run",   64'(busy_o),    64'h0);
    send_ctrl(8'd0, 8'h01, 8'd0);
    @(negedge clk_i);
    chk("t5_after_badch",    64'(busy_o),    64'h0001);
    send_ctrl(8'd0, 8'h07, 8'd0);
    chk("t5_mode3_err",      64'(cmd_err_o), 64'h1);
    @(negedge clk_i);
    chk("t5_mode3_disable",  64'(busy_o),      64'h0);
    chk("t5_mode3_no_done",  64'(done_tick_o), 64'h0);

    // 6: asynchronous reset mid-run and mid-command
    send_period(8'd1, 8'd1, 8'd1, 8'd1);
    send_ctrl(8'd5, 8'h03, 8'd0);
    send_byte(8'h01); send_byte(8'd5); send_byte(8'hAA);
    chk("t6_running",        64'(busy_o[5]), 64'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_async_serial",   64'(serial_out_o), 64'h0);
    chk("t6_async_busy",     64'(busy_o),       64'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    send_data(8'd1, 32'h0000_0001);
    send_ctrl(8'd1, 8'h01, 8'd0);
    measure(1, 700, bn, lb, hn, fh, lh, dn, da);
    chk("t6_busy_default",   64'(bn), 64'd640);
    chk("t6_high_default",   64'(hn), 64'd20);
    chk("t6_done_default",   64'(dn), 64'd1);
    send_period(8'd0, 8'd0, 8'd0, 8'd0);
    send_ctrl(8'd1, 8'h01, 8'd0);
    measure(1, 40, bn, lb, hn, fh, lh, dn, da);
    chk("t6_p0_busy",        64'(bn), 64'd32);
    chk("t6_p0_high",        64'(hn), 64'd1);
    chk("t6_p0_done_at",     64'(da), 64'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_freq_serial_out.md
Name: multi_freq_serial_out

Overview:
Parametrised successor to the two-speed serial output generator. A byte-stream command parser is fed from the UART receiver (data byte plus one-cycle valid tick). It drives OUTPUT_NUM independent serial channels. Each data bit is held for one of PERIOD_NUM programmable periods, selected per bit by a shared frequency-select pattern. Adds repeat-N counts, double-buffered data updates, a stop command, and per-channel status.

Parameters:
DATA_BIT, 32, bits per channel pattern; shifted out LSB first.
OUTPUT_NUM, 16, number of serial channels (1..64).
PERIOD_NUM, 4, number of selectable bit periods (power of 2, 2..16); SEL_W = log2(PERIOD_NUM).
PERIOD_W, 8, width of each period register.
DEFAULT_PERIODS, {8'd40,8'd10,8'd5,8'd20}, reset values of periods, index 0 in the LSBs.
CMD_DATA, 8'h01; CMD_CTRL, 8'h02; CMD_FREQ, 8'h03; CMD_PERIOD, 8'h04; CMD_STOP, 8'h05: command codes.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
data_i  in  8  received byte; valid only when rx_done_tick_i=1
rx_done_tick_i  in  1  one-cycle byte strobe
serial_out_o  out  OUTPUT_NUM  serial outputs; idle low
busy_o  out  OUTPUT_NUM  channel is running a pattern
done_tick_o  out  OUTPUT_NUM  one-cycle pulse when a run sequence completes
cmd_err_o  out  1  one-cycle pulse on a malformed command

Behaviour:
- Reset: serial_out_o=0, busy_o=0, done_tick_o=0, cmd_err_o=0. Parser goes to IDLE. All data, shadow and freq-select registers = 0. Periods = DEFAULT_PERIODS.
- Bytes are consumed only on rx_done_tick_i. There is no timeout; a partial command waits indefinitely.
- Parser states: IDLE -> on a command byte, go to the command-specific byte sequence, then return to IDLE.
  - DATA: ch, then DATA_BIT/8 pattern bytes, LSB byte first.
  - CTRL: ch, ctrl{[7:3]=0, [2:1]=mode, [0]=en}, repcnt.
  - FREQ: DATA_BIT*SEL_W/8 bytes, LSB first. Bits [b*SEL_W +: SEL_W] select the period of data bit b.
  - PERIOD: PERIOD_NUM bytes, index 0 first (PERIOD_W=8).
  - STOP: ch (8'hFF = all channels).
- Unknown byte in IDLE: parser stays in IDLE and pulses cmd_err_o.
- ch >= OUTPUT_NUM (and not 8'hFF for STOP): remaining bytes are still consumed, the command has no effect, and cmd_err_o pulses on the last byte.
- Mode 2'b11: the channel is disabled and cmd_err_o pulses.
- DATA write: goes to the channel's shadow register.
  - Idle channel: shadow copies to active on the same edge.
  - Busy channel: active reloads from shadow only at the start of the next run, never mid-pattern.
- FREQ and PERIOD values are global. They are sampled per bit when that bit starts, so a change affects the next bit of every running channel.
- CTRL with en=1: timing is counted in clock edges after the edge that samples the final byte's tick.
  - Edge 1: channel loads the active pattern; busy_o=1; serial_out_o=bit0.
  - Each bit b is held for P cycles, P = period[sel[b]]; P=0 is treated as 1.
  - A run is DATA_BIT bits.
- Modes:
  - 00 one-shot: 1 run.
  - 01 repeat: runs until disabled.
  - 10 repeat-N: repcnt runs; repcnt=0 is treated as 1.
  - Consecutive runs are gapless: bit0 of run k+1 directly follows the last cycle of run k.
- Completion (modes 00/10): on the edge after the last bit's final cycle, serial_out_o=0, busy_o=0, and done_tick_o pulses for exactly 1 cycle.
- CTRL en=1 on a busy channel: restarts immediately from bit0, with a fresh repeat count and the shadow pattern. No done_tick_o.
- CTRL en=0, or STOP: the channel goes idle on the next edge with output low and no done_tick_o.
- Simultaneous completion and a new CTRL on the same edge: the CTRL wins (restart) and done_tick_o is suppressed.
- Channels are fully independent; all counters saturate-free and wrap only at their run boundaries.
- Asserting rst_ni mid-pattern forces all outputs low asynchronously. A partial command is discarded.

Test Plan:
1. Reset, then CTRL ch0 mode00 en=1 with data 0 -> serial_out_o[0] stays 0; busy_o[0] high for 32*20=640 cycles (sel=0 -> period 20); done_tick_o[0] pulses once.
2. FREQ=0x..E4E4 (sels 0,1,2,3 repeating), PERIOD {20,5,10,40}, DATA ch3=0x0000000F, CTRL mode00 en -> ch3 high for 20+5+10+40 cycles from edge 1, then low; total busy = 8*(20+5+10+40)=600 cycles.
3. DATA ch5=0x55555555, CTRL mode10 repcnt=3 -> exactly 3 gapless runs, a single done_tick_o[5] at the end; repcnt=0 gives exactly 1 run.
4. Mode01 on ch7; write DATA 0xFFFFFFFF mid-run -> the current run finishes with the old pattern and the next run is all high; STOP ch 8'hFF -> all outputs low next edge, no done_tick_o.
5. Byte 8'h7E in IDLE -> cmd_err_o pulse, no state change. CTRL ch=16 -> all 4 bytes consumed, cmd_err_o pulse, no channel affected.
6. Assert rst_ni mid-run and mid-DATA-command -> outputs 0 immediately; after release, a fresh CTRL works normally and the periods are back at defaults.
